// File: rtl/tx_arbiter_pkg.sv
// Shared encodings for the transmitter arbiter: transmitter states, arbiter FSM
// states and the grant-index width helper.
package tx_arbiter_pkg;

  typedef enum logic [1:0] {
    TX_START = 2'd0,
    TX_SHIFT = 2'd1,
    TX_STOP1 = 2'd2,
    TX_STOP2 = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  // GRANT_W = clog2(NUM_REQ), never narrower than one bit
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set req index after last, modulo NUM_REQ.
module rr_pick
  import tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last,
  output logic               found,
  output logic [GRANT_W-1:0] index
);

  logic [GRANT_W-1:0] cand;

  // Walk from the farthest candidate down so the nearest set bit wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GRANT_W'((int'(last) + k) % NUM_REQ);
      if (req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one serial byte transmitter among
// NUM_REQ requesters; launches frames, tracks tx_state and acks on completion.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 4,
  localparam int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      tx_go,
  output logic [DATA_W-1:0]         tx_data,
  input  logic [1:0]                tx_state,
  output logic                      busy,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      stall_err,
  output logic [15:0]               frame_count
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e         state, state_nx;
  logic [GRANT_W-1:0] last;
  logic [GRANT_W-1:0] pick;
  logic               found;
  logic [CNT_W-1:0]   tcnt;
  logic               grant;
  logic               stall;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req),
    .last  (last),
    .found (found),
    .index (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Grant waits for START so a stale frame from the un-reset transmitter drains first.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (found && tx_state == TX_START) begin
          state_nx = LAUNCH;
          grant    = 1'b1;
        end
      end
      LAUNCH: begin
        if (tx_state == TX_SHIFT) begin
          state_nx = ACTIVE;
        end else if (tcnt == CNT_W'(TIMEOUT - 1)) begin
          state_nx = IDLE;
          stall    = 1'b1;
        end
      end
      ACTIVE: begin
        if (tx_state == TX_STOP2 || tx_state == TX_START) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id    <= '0;
      tx_data     <= '0;
      tcnt        <= '0;
      stall_err   <= 1'b0;
      frame_count <= '0;
      last        <= GRANT_W'(NUM_REQ - 1);
    end else begin
      stall_err <= stall;
      if (grant) begin
        grant_id <= pick;
        tx_data  <= req_data[pick*DATA_W +: DATA_W];
        tcnt     <= '0;
      end else if (state == LAUNCH) begin
        tcnt <= tcnt + 1'b1;
      end
      if (state == DONE) begin
        frame_count <= frame_count + 16'd1;
        last        <= grant_id;
      end
    end
  end

  assign tx_go = (state == LAUNCH);
  assign busy  = (state != IDLE);
  assign ack   = (state == DONE) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id) : '0;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter with a behavioural transmitter and a
// transaction-level round-robin reference model.
module tb_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    ack;
  logic            tx_go;
  logic [DW-1:0]   tx_data;
  logic [1:0]      tx_state;
  logic            busy;
  logic [1:0]      grant_id;
  logic            stall_err;
  logic [15:0]     frame_count;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          m_last = N - 1;
  logic [15:0] m_fc = 16'd0;
  int          last_ack_cyc = 0;

  tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_go       (tx_go),
    .tx_data     (tx_data),
    .tx_state    (tx_state),
    .busy        (busy),
    .grant_id    (grant_id),
    .stall_err   (stall_err),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: no reset; 9 SHIFT cycles, STOP1, STOP2, back to START.
  logic [1:0] txm = 2'd0;
  int         txcnt = 0;
  bit         stuck = 1'b0;

  always @(posedge clk) begin
    case (txm)
      2'd0: if (tx_go && !stuck) begin txm <= 2'd1; txcnt <= 0; end
      2'd1: if (txcnt == 8) txm <= 2'd2; else txcnt <= txcnt + 1;
      2'd2: txm <= 2'd3;
      default: txm <= 2'd0;
    endcase
  end

  assign tx_state = txm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_ref(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic set_data(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  // One complete frame: predicts the winner, then checks launch, data hold, ack and count.
  task automatic run_frame(input string tag, input int mode, input logic [N-1:0] ovr,
                           input bit chk_gap);
    int w, n;
    logic [1:0] wi;
    logic [DW-1:0] ed;
    bit bad;
    w = rr_ref(req, m_last);
    if (w < 0) begin
      chk({tag, "_noreq"}, 32'd0, 32'd1);
      return;
    end
    wi = 2'(w);
    ed = req_data[w*DW +: DW];
    n = 0;
    while (tx_go !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (tx_go !== 1'b1) begin
      chk({tag, "_go_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({tag, "_gid"}, 32'(grant_id), 32'(w));
    chk({tag, "_data"}, 32'(tx_data), 32'(ed));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    set_data(w, ed ^ 8'hFF);
    bad = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2) chk({tag, "_go_low"}, 32'(tx_go), 32'd0);
      if (tx_data !== ed) bad = 1'b1;
    end while (ack == '0 && n < 30);
    chk({tag, "_ack_lat"}, 32'(n), 32'd12);
    chk({tag, "_ack"}, 32'(ack), 32'(4'b0001 << wi));
    chk({tag, "_hold"}, 32'(bad), 32'd0);
    if (chk_gap) chk({tag, "_gap"}, 32'(cyc - last_ack_cyc), 32'd14);
    last_ack_cyc = cyc;
    m_last = w;
    m_fc = m_fc + 16'd1;
    req[wi] = 1'b0;
    if (mode == 1) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i] = 1'b1;
          set_data(i, 8'($urandom));
        end
      end
      if (req == '0) begin
        int j;
        j = $urandom_range(0, N - 1);
        req[j[1:0]] = 1'b1;
        set_data(j, 8'($urandom));
      end
    end else if (mode == 2) begin
      req = ovr;
      for (int i = 0; i < N; i++) set_data(i, 8'($urandom));
    end
    @(negedge clk);
    chk({tag, "_ack_pulse"}, 32'(ack), 32'd0);
    chk({tag, "_fcount"}, 32'(frame_count), 32'(m_fc));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = N - 1;
    m_fc = 16'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit bad;
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    #1;
    chk("rst_go", 32'(tx_go), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_stall", 32'(stall_err), 32'd0);
    chk("rst_fcount", 32'(frame_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request
    req = 4'b0001;
    set_data(0, 8'hA5);
    @(negedge clk);
    chk("single_go_lat", 32'(tx_go), 32'd1);
    chk("single_data0", 32'(tx_data), 32'hA5);
    run_frame("single", 0, '0, 1'b0);

    // Contention, then fairness with a reduced request set after grant 2
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_data(i, 8'(8'h10 + i));
    run_frame("cont0", 0, '0, 1'b0);
    run_frame("cont1", 0, '0, 1'b1);
    run_frame("cont2", 2, 4'b0101, 1'b1);
    chk("fair_next", 32'(rr_ref(req, m_last)), 32'd0);
    run_frame("fair0", 0, '0, 1'b1);
    run_frame("fair1", 0, '0, 1'b1);

    // Stall: transmitter stuck in START
    stuck = 1'b1;
    req = 4'b0001;
    set_data(0, 8'h3C);
    n = 0;
    @(negedge clk);
    while (tx_go && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("stall_len", 32'(n), 32'd4);
    chk("stall_err", 32'(stall_err), 32'd1);
    chk("stall_ack", 32'(ack), 32'd0);
    chk("stall_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("stall_regrant", 32'(tx_go), 32'd1);
    chk("stall_pulse", 32'(stall_err), 32'd0);
    chk("stall_gid", 32'(grant_id), 32'd0);
    stuck = 1'b0;
    n = 0;
    while (ack == '0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("stall_ack_end", 32'(ack), 32'd1);
    m_last = 0;
    m_fc = m_fc + 16'd1;
    req = '0;
    @(negedge clk);
    chk("stall_fcount", 32'(frame_count), 32'(m_fc));

    // Reset during SHIFT
    req = 4'b0010;
    set_data(1, 8'h77);
    n = 0;
    while (!tx_go && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_go", 32'(tx_go), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_gid", 32'(grant_id), 32'd0);
    chk("mrst_data", 32'(tx_data), 32'd0);
    chk("mrst_fcount", 32'(frame_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = N - 1;
    m_fc = 16'd0;
    bad = 1'b0;
    n = 0;
    while (tx_state != 2'd0 && n < 20) begin
      if (tx_go) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    if (tx_go) bad = 1'b1;
    chk("mrst_early_go", 32'(bad), 32'd0);
    run_frame("mrst", 0, '0, 1'b0);

    // Frame counter wrap
    force dut.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count;
    m_fc = 16'hFFFF;
    req = 4'b0100;
    set_data(2, 8'hC3);
    run_frame("wrap", 0, '0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < N; i++) begin
      req[i] = ($urandom_range(0, 1) == 1);
      set_data(i, 8'($urandom));
    end
    if (req == '0) req[3] = 1'b1;
    for (int f = 0; f < 30; f++) run_frame("rnd", 1, '0, f > 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
